jk_ff_advanced: RTL and testbench



---
 rtl/jk_pkg.sv | 31 +++
 rtl/jk_ff_cell.sv | 33 +++
 rtl/jk_ff_advanced.sv | 44 ++++
 tb/tb_jk_ff_advanced.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_pkg
// Brief    : JK operation encoding and next-state helper shared by the bank.
// Revision : 1.0 - initial release
// ============================================================================
package jk_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        CLEAR  = 2'b01,
        SET    = 2'b10,
        TOGGLE = 2'b11
    } jk_op_t;

    // Unknown encodings fall to hold so X on J/K never corrupts a valid state.
    function automatic logic jk_next(input jk_op_t op, input logic q);
        logic w_next;
        w_next = q;
        case (op)
            HOLD:    w_next = q;
            CLEAR:   w_next = 1'b0;
            SET:     w_next = 1'b1;
            TOGGLE:  w_next = ~q;
            default: w_next = q;
        endcase
        return w_next;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jk_ff_cell.sv
`default_nettype none
// ============================================================================
// Module   : jk_ff_cell
// Brief    : Single-bit clock-enabled JK flip-flop, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module jk_ff_cell
    import jk_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset_async,
    input  logic enable,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or negedge reset_async) begin
        if (!reset_async) begin
            r_q <= RESET_VALUE;
        end else if (enable) begin
            r_q <= jk_next(jk_op_t'({j, k}), r_q);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/jk_ff_advanced.sv
`default_nettype none
// ============================================================================
// Module   : jk_ff_advanced
// Brief    : Bank of WIDTH independent JK flip-flops with complementary outputs.
// Revision : 1.0 - initial release
// ============================================================================
module jk_ff_advanced
    import jk_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_async,
    input  logic             enable,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar
);

    logic [WIDTH-1:0] w_q;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_ff_cell #(
                .RESET_VALUE (RESET_VALUE[gi])
            ) u_cell (
                .clk         (clk),
                .reset_async (reset_async),
                .enable      (enable),
                .j           (J[gi]),
                .k           (K[gi]),
                .q           (w_q[gi])
            );
        end
    endgenerate

    // Q_bar is derived, not registered, so it can never disagree with Q.
    assign Q     = w_q;
    assign Q_bar = ~w_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_ff_advanced.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_ff_advanced
// Brief    : Directed table-driven bench for 1-bit and 4-bit JK banks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jk_ff_advanced;

    typedef struct {
        logic en;
        logic j;
        logic k;
        logic q;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [0:0] j;
    logic [0:0] k;
    logic [0:0] q;
    logic [0:0] qb;

    logic       rst4_n;
    logic       en4;
    logic [3:0] j4;
    logic [3:0] k4;
    logic [3:0] q4;
    logic [3:0] qb4;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    jk_ff_advanced u_dut1 (
        .clk         (clk),
        .reset_async (rst_n),
        .enable      (en),
        .J           (j),
        .K           (k),
        .Q           (q),
        .Q_bar       (qb)
    );

    jk_ff_advanced #(
        .WIDTH       (4),
        .RESET_VALUE (4'b1010)
    ) u_dut4 (
        .clk         (clk),
        .reset_async (rst4_n),
        .enable      (en4),
        .J           (j4),
        .K           (k4),
        .Q           (q4),
        .Q_bar       (qb4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic [3:0] exp_q);
        check({name, " Q"}, {3'b000, q}, exp_q);
        check({name, " Q_bar"}, {3'b000, qb}, {3'b000, ~exp_q[0]});
    endtask

    initial begin
        rst_n  = 1'b0;
        rst4_n = 1'b0;
        en     = 1'b0;
        j      = 'x;
        k      = 'x;
        en4    = 1'b0;
        j4     = '0;
        k4     = '0;

        // Reset phase: J/K undriven, both banks held in reset
        for (int t = 0; t < 3; t++) begin
            #30;
            check1("reset", 4'b0000);
            check("reset no-X", {3'b000, $isunknown({q, qb})}, 4'b0000);
            check("reset4 Q", q4, 4'b1010);
            check("reset4 Q_bar", qb4, 4'b0101);
        end
        #10;
        @(negedge clk);
        rst_n = 1'b1;

        // enable low: nothing moves
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0});
        for (int n = 0; n < 10; n++) vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0});
        // truth table then sustained toggle
        vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b1});

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge clk);
            en = vecs[n].en;
            j  = vecs[n].j;
            k  = vecs[n].k;
            @(posedge clk);
            #1;
            check1($sformatf("vec%0d", n), {3'b000, vecs[n].q});
        end

        // Async reset mid-toggle (Q=1 now), released 1 ns before an edge
        #4;
        rst_n = 1'b0;
        #1;
        check1("async reset mid-cycle", 4'b0000);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("first edge after release", 4'b0001);
        @(posedge clk);
        #1;
        check1("second edge after release", 4'b0000);

        // Reset coincident with a clock edge while setting
        @(negedge clk);
        j = 1'b1;
        k = 1'b0;
        @(posedge clk);
        #1;
        check1("set before collision", 4'b0001);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check1("reset/edge collision", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check1("set after collision", 4'b0001);

        // 4-bit bank with non-zero reset value, mixed per-bit ops
        @(negedge clk);
        rst4_n = 1'b1;
        en4    = 1'b1;
        j4     = 4'b0011;
        k4     = 4'b0101;
        @(posedge clk);
        #1;
        check("w4 edge1 Q", q4, 4'b1011);
        check("w4 edge1 Q_bar", qb4, 4'b0100);
        @(posedge clk);
        #1;
        check("w4 edge2 Q", q4, 4'b1010);
        @(negedge clk);
        en4 = 1'b0;
        @(posedge clk);
        #1;
        check("w4 hold Q", q4, 4'b1010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
